// File: rtl/add_pkg.sv
// Shared types for the wide-add beat sequencer.
package add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } add_seq_state_t;

endpackage

// File: rtl/add_nnbit_ahead_serial.sv
// DATA_WIDTH-bit combinational adder slice with carry-in and carry-out.
module add_nnbit_ahead_serial #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_num_a,
   input  logic [DATA_WIDTH-1:0] i_num_b,
   input  logic                  i_cry,
   output logic [DATA_WIDTH-1:0] o_res,
   output logic                  o_cry
);

   logic [DATA_WIDTH-1:0] gen;
   logic [DATA_WIDTH-1:0] prop;
   logic [DATA_WIDTH:0]   carry;

   assign gen  = i_num_a & i_num_b;
   assign prop = i_num_a ^ i_num_b;

   // Generate/propagate carry chain; synthesis flattens it into lookahead logic.
   always_comb begin
      carry    = '0;
      carry[0] = i_cry;
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
         carry[i+1] = gen[i] | (prop[i] & carry[i]);
      end
   end

   assign o_res = prop ^ carry[DATA_WIDTH-1:0];
   assign o_cry = carry[DATA_WIDTH];

endmodule

// File: rtl/add_nnbit_beat_seq.sv
// Feeds wide operands to a DATA_WIDTH adder one slice per cycle, LSB first,
// and presents the assembled sum, carry and overflow on a valid/ready handshake.
module add_nnbit_beat_seq
   import add_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BEAT_NUM   = 4
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_valid,
   output logic                             o_ready,
   input  logic [DATA_WIDTH*BEAT_NUM-1:0]   i_num_a,
   input  logic [DATA_WIDTH*BEAT_NUM-1:0]   i_num_b,
   input  logic                             i_cry,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic [DATA_WIDTH*BEAT_NUM-1:0]   o_res,
   output logic                             o_cry,
   output logic                             o_ovf,
   output logic                             o_busy
);

   localparam int unsigned TOTAL_WIDTH = DATA_WIDTH * BEAT_NUM;
   localparam int unsigned CW          = $clog2(BEAT_NUM);

   add_seq_state_t         state;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_inc;
   logic                   inc_carry;
   logic                   carry_reg;
   logic [TOTAL_WIDTH-1:0] a_reg;
   logic [TOTAL_WIDTH-1:0] b_reg;
   logic [DATA_WIDTH-1:0]  sl_a;
   logic [DATA_WIDTH-1:0]  sl_b;
   logic [DATA_WIDTH-1:0]  sum;
   logic                   sum_cry;
   logic                   last_beat;

   // Slice select for the current beat.
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int k = 0; k < int'(BEAT_NUM); k++) begin
         if (cnt == CW'(k)) begin
            sl_a = a_reg[k*DATA_WIDTH +: DATA_WIDTH];
            sl_b = b_reg[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Beat counter increment built from toggles so the adder stays the only arithmetic.
   always_comb begin
      cnt_inc   = '0;
      inc_carry = 1'b1;
      for (int i = 0; i < int'(CW); i++) begin
         cnt_inc[i] = cnt[i] ^ inc_carry;
         inc_carry  = inc_carry & cnt[i];
      end
   end

   assign last_beat = (cnt == CW'(BEAT_NUM - 1));

   add_nnbit_ahead_serial #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_adder (
      .i_num_a (sl_a),
      .i_num_b (sl_b),
      .i_cry   (carry_reg),
      .o_res   (sum),
      .o_cry   (sum_cry)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         o_res     <= '0;
         o_cry     <= 1'b0;
         o_ovf     <= 1'b0;
         o_valid   <= 1'b0;
         o_ready   <= 1'b1;
         o_busy    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_valid) begin
                  a_reg     <= i_num_a;
                  b_reg     <= i_num_b;
                  carry_reg <= i_cry;
                  cnt       <= '0;
                  o_ready   <= 1'b0;
                  o_busy    <= 1'b1;
                  state     <= ST_CALC;
               end
            end
            ST_CALC: begin
               for (int k = 0; k < int'(BEAT_NUM); k++) begin
                  if (cnt == CW'(k)) begin
                     o_res[k*DATA_WIDTH +: DATA_WIDTH] <= sum;
                  end
               end
               carry_reg <= sum_cry;
               cnt       <= cnt_inc;
               if (last_beat) begin
                  o_cry   <= sum_cry;
                  // On the last beat the slice MSBs are the full-width sign bits.
                  o_ovf   <= (sl_a[DATA_WIDTH-1] == sl_b[DATA_WIDTH-1]) &&
                             (sum[DATA_WIDTH-1] != sl_a[DATA_WIDTH-1]);
                  o_valid <= 1'b1;
                  o_busy  <= 1'b0;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               o_valid <= 1'b0;
               o_ready <= 1'b1;
               o_busy  <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_nnbit_beat_seq.sv
// Directed bench for add_nnbit_beat_seq (DATA_WIDTH=8, BEAT_NUM=4).
module tb_add_nnbit_beat_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] num_a;
   logic [31:0] num_b;
   logic        cry_in;
   logic        out_valid;
   logic        down_ready;
   logic [31:0] res;
   logic        cry_out;
   logic        ovf;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   add_nnbit_beat_seq #(
      .DATA_WIDTH (8),
      .BEAT_NUM   (4)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (in_valid),
      .o_ready (out_ready),
      .i_num_a (num_a),
      .i_num_b (num_b),
      .i_cry   (cry_in),
      .o_valid (out_valid),
      .i_ready (down_ready),
      .o_res   (res),
      .o_cry   (cry_out),
      .o_ovf   (ovf),
      .o_busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!out_ready && n < 20) begin
         step();
         n++;
      end
      chk("wait_ready", 64'(out_ready), 64'd1);
   endtask

   // Capture, check latency window, check result, then drain.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [31:0] exp_res,
                         input logic exp_cry, input logic exp_ovf);
      wait_ready();
      num_a    = a;
      num_b    = b;
      cry_in   = c;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk({tag, "_lat_lo"}, 64'(out_valid), 64'd0);
      end
      step();
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_res"},   64'(res),       64'(exp_res));
      chk({tag, "_cry"},   64'(cry_out),   64'(exp_cry));
      chk({tag, "_ovf"},   64'(ovf),       64'(exp_ovf));
      down_ready = 1'b1;
      step();
      down_ready = 1'b0;
      chk({tag, "_drop"},  64'(out_valid), 64'd0);
   endtask

   logic [31:0] va [4];
   logic [31:0] vb [4];
   logic        vc [4];

   initial begin
      logic [32:0] gold;
      logic        gold_ovf;
      int idx_in, idx_out, last_cap;
      logic prev_busy;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      down_ready = 1'b0;
      num_a      = '0;
      num_b      = '0;
      cry_in     = 1'b0;
      step();
      step();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(out_ready), 64'd1);
      chk("rst_res",   64'(res),       64'd0);
      chk("rst_cry",   64'(cry_out),   64'd0);
      chk("rst_ovf",   64'(ovf),       64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      rst_n = 1'b1;
      step();

      run_op("t1", 32'hF0F0F0F0, 32'hF0F0F0F0, 1'b0, 32'hE1E1E1E0, 1'b1, 1'b0);
      run_op("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
      run_op("t3", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);

      // Backpressure hold with an ignored request in the window.
      wait_ready();
      num_a    = 32'h0000FFFF;
      num_b    = 32'h00000001;
      cry_in   = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t4_busy", 64'(busy), 64'd1);
      num_a = 32'hAAAAAAAA;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("t4_lat_lo", 64'(out_valid), 64'd0);
      end
      step();
      chk("t4_valid", 64'(out_valid), 64'd1);
      chk("t4_res",   64'(res),       64'h00010000);
      in_valid = 1'b1;
      num_a    = 32'h11111111;
      num_b    = 32'h22222222;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_hold_valid", 64'(out_valid), 64'd1);
         chk("t4_hold_res",   64'(res),       64'h00010000);
         chk("t4_hold_ready", 64'(out_ready), 64'd0);
      end
      in_valid   = 1'b0;
      down_ready = 1'b1;
      step();
      down_ready = 1'b0;
      chk("t4_drop",  64'(out_valid), 64'd0);
      chk("t4_ready", 64'(out_ready), 64'd1);
      step();
      step();
      chk("t4_noqueue_busy", 64'(busy), 64'd0);
      chk("t4_keep_res",     64'(res),  64'h00010000);

      // Reset during beat 2, then rerun the same operation.
      wait_ready();
      num_a    = 32'h12345678;
      num_b    = 32'h11111111;
      cry_in   = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("t5_valid", 64'(out_valid), 64'd0);
      chk("t5_res",   64'(res),       64'd0);
      chk("t5_cry",   64'(cry_out),   64'd0);
      chk("t5_ovf",   64'(ovf),       64'd0);
      chk("t5_busy",  64'(busy),      64'd0);
      chk("t5_ready", 64'(out_ready), 64'd1);
      step();
      rst_n = 1'b1;
      step();
      run_op("t5_rerun", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

      // Back-to-back with valid held and sink always ready.
      va[0] = 32'h12345678; vb[0] = 32'h11111111; vc[0] = 1'b0;
      va[1] = 32'h80000000; vb[1] = 32'h80000000; vc[1] = 1'b0;
      va[2] = 32'hDEADBEEF; vb[2] = 32'h01234567; vc[2] = 1'b1;
      va[3] = 32'h7FFFFFFF; vb[3] = 32'h7FFFFFFF; vc[3] = 1'b1;
      idx_in     = 0;
      idx_out    = 0;
      last_cap   = 0;
      prev_busy  = busy;
      num_a      = va[0];
      num_b      = vb[0];
      cry_in     = vc[0];
      in_valid   = 1'b1;
      down_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && idx_out < 4; cyc++) begin
         step();
         if (busy && !prev_busy) begin
            if (idx_in > 0) chk("t6_spacing", 64'(cyc - last_cap), 64'd6);
            last_cap = cyc;
            idx_in++;
            if (idx_in < 4) begin
               num_a  = va[idx_in];
               num_b  = vb[idx_in];
               cry_in = vc[idx_in];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid && idx_out < 4) begin
            gold     = 33'(va[idx_out]) + 33'(vb[idx_out]) + 33'(vc[idx_out]);
            gold_ovf = (va[idx_out][31] == vb[idx_out][31]) && (gold[31] != va[idx_out][31]);
            chk("t6_res", 64'(res),     64'(gold[31:0]));
            chk("t6_cry", 64'(cry_out), 64'(gold[32]));
            chk("t6_ovf", 64'(ovf),     64'(gold_ovf));
            idx_out++;
         end
         prev_busy = busy;
      end
      in_valid   = 1'b0;
      down_ready = 1'b0;
      chk("t6_results", 64'(idx_out), 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
